// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Serializes both requesters, registers every output and aborts an access that stalls too long.
module riscv_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit DATA_PRIO      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_size_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wd_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_e;

  // Counter value seen on the last BUSY edge before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_size_d = mem_size_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_req_i && (DATA_PRIO || !last_d_q || !if_req_i)) begin
          state_d    = BUSY_D;
          last_d_d   = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = d_we_i;
          mem_size_d = d_size_i;
          mem_addr_d = d_addr_i;
          mem_wd_d   = d_wd_i;
        end else if (if_req_i) begin
          state_d    = BUSY_IF;
          last_d_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_size_d = 3'b010;
          mem_addr_d = if_addr_i;
          mem_wd_d   = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        cnt_d = cnt_q + 8'd1;
        // A ready arriving on the timeout edge still completes normally.
        if (mem_ready_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata_d = mem_rd_i;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rd_i;
            if_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_D) begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_size_q <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_size_q <= mem_size_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign if_rdata_o = if_rdata_q;
  assign if_valid_o = if_valid_q;
  assign d_rdata_o  = d_rdata_q;
  assign d_valid_o  = d_valid_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_size_o = mem_size_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: one instance with data priority, one with round-robin,
// each driven by random request rounds and checked against a transaction-level model.
module tb_riscv_mem_arbiter;

  localparam int TMO      = 4;
  localparam int N_ROUNDS = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_env
    localparam bit PRIO = (gi == 0);

    logic        rst, if_req, d_req, d_we, mem_ready;
    logic [2:0]  d_size;
    logic [31:0] if_addr, d_addr, d_wd, mem_rd;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wd;
    logic        if_valid, d_valid, err, busy, mem_req, mem_we;
    logic [2:0]  mem_size;
    bit          env_done = 1'b0;

    // Model state: who was granted last, and what each requester last received.
    bit          last_fetch;
    logic [31:0] exp_if_rd, exp_d_rd;

    riscv_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .DATA_PRIO(PRIO)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
      .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wd_i(d_wd),
      .d_rdata_o(d_rdata), .d_valid_o(d_valid), .err_o(err), .busy_o(busy),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size), .mem_addr_o(mem_addr),
      .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    function automatic string tg(input string s);
      return $sformatf("prio%0d.%s", PRIO, s);
    endfunction

    task automatic check_zero_outputs(input string s);
      check(tg({s, ".if_rdata"}), if_rdata, 64'd0);
      check(tg({s, ".d_rdata"}), d_rdata, 64'd0);
      check(tg({s, ".mem_addr"}), mem_addr, 64'd0);
      check(tg({s, ".mem_wd"}), mem_wd, 64'd0);
      check(tg({s, ".ctrl"}), {if_valid, d_valid, err, busy, mem_req, mem_we, mem_size}, 64'd0);
    endtask

    // One access: wait for the grant, play the memory with the given latency, check completion.
    task automatic serve(input bit is_d, input int exp_lat, input int lat, input logic [31:0] rd,
                         input bit drop_early, input bit hold);
      int          cyc;
      int          k;
      bit          tmo;
      logic [31:0] exp_addr;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        mem_ready = 1'b0;
        mem_rd    = $urandom;
        if (cyc == 1) check(tg("pulse_clear"), {if_valid, d_valid, err}, 64'd0);
      end while (!mem_req && cyc < 10);
      exp_addr = is_d ? d_addr : if_addr;
      check(tg("grant_lat"), cyc, exp_lat);
      check(tg("busy_grant"), busy, 64'd1);
      check(tg("mem_addr"), mem_addr, exp_addr);
      check(tg("mem_we"), mem_we, is_d ? d_we : 1'b0);
      check(tg("mem_size"), mem_size, is_d ? d_size : 3'b010);
      check(tg("mem_wd"), mem_wd, is_d ? d_wd : 32'd0);
      k         = 1;
      mem_ready = (lat == 0);
      mem_rd    = mem_ready ? rd : $urandom;
      if (drop_early) begin
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      while (!(if_valid || d_valid) && k < TMO + 4) begin
        @(negedge clk);
        k++;
        if (!(if_valid || d_valid)) check(tg("req_held"), {mem_req, mem_addr}, {1'b1, exp_addr});
        mem_ready = (k == lat + 1);
        mem_rd    = mem_ready ? rd : $urandom;
      end
      tmo = (lat >= TMO);
      check(tg("resp_lat"), k, tmo ? TMO + 1 : lat + 2);
      if (is_d) exp_d_rd = tmo ? 32'd0 : rd;
      else exp_if_rd = tmo ? 32'd0 : rd;
      check(tg("valids"), {if_valid, d_valid}, {!is_d, is_d});
      check(tg("err"), err, tmo);
      check(tg("if_rdata"), if_rdata, exp_if_rd);
      check(tg("d_rdata"), d_rdata, exp_d_rd);
      check(tg("resp_req_busy"), {mem_req, busy}, 64'b01);
      if (!hold) begin
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
    endtask

    initial begin
      logic [31:0] rd_if, rd_d;
      int          lat_if, lat_d;
      bit          want_if, want_d, d_first, drop_if, drop_d;
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      d_size = '0; if_addr = '0; d_addr = '0; d_wd = '0; mem_rd = '0;
      last_fetch = 1'b1; exp_if_rd = '0; exp_d_rd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      for (int r = 0; r < N_ROUNDS; r++) begin
        want_if = 1'($urandom_range(0, 1));
        want_d  = 1'($urandom_range(0, 1));
        if (!want_if && !want_d) want_if = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
        d_addr  = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_size  = 3'($urandom_range(0, 7));
        d_wd    = $urandom;
        lat_if  = $urandom_range(0, TMO + 1);
        lat_d   = $urandom_range(0, TMO + 1);
        rd_if   = $urandom;
        rd_d    = $urandom;
        drop_if = ($urandom_range(0, 3) == 0);
        drop_d  = ($urandom_range(0, 3) == 0);
        case (r)
          0: begin want_if = 1'b1; want_d = 1'b0; if_addr = 32'h10; lat_if = 2; rd_if = 32'h0050_0093; end
          1: begin want_if = 1'b1; want_d = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wd = 32'hDEAD_BEEF; d_size = 3'b010; end
          2: begin want_if = 1'b0; want_d = 1'b1; lat_d = TMO - 1; end
          3: begin want_if = 1'b0; want_d = 1'b1; lat_d = TMO; end
          default: ;
        endcase
        d_first    = want_d && (PRIO || last_fetch || !want_if);
        if_req     = want_if;
        d_req      = want_d;
        last_fetch = !d_first;
        if (d_first) serve(1'b1, 1, lat_d, rd_d, drop_d, 1'b0);
        else serve(1'b0, 1, lat_if, rd_if, drop_if, 1'b0);
        if (want_if && want_d) begin
          last_fetch = d_first;
          if (d_first) serve(1'b0, 2, lat_if, rd_if, drop_if, 1'b0);
          else serve(1'b1, 2, lat_d, rd_d, drop_d, 1'b0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        check(tg("idle_state"), {busy, mem_req, if_valid, d_valid, err}, 64'd0);
        if (r == 0 || $urandom_range(0, 2) == 0) begin
          mem_ready = 1'b1;
          mem_rd    = (r == 0) ? 32'h1234_5678 : $urandom;
          @(negedge clk);
          mem_ready = 1'b0;
          check(tg("stray_ready"), {if_valid, d_valid, busy, err}, 64'd0);
          check(tg("stray_if_rdata"), if_rdata, exp_if_rd);
          check(tg("stray_d_rdata"), d_rdata, exp_d_rd);
        end
      end

      // Reset while a fetch is in flight; a late ready must not complete it.
      if_req  = 1'b1;
      if_addr = $urandom;
      @(negedge clk);
      check(tg("midrst_busy"), {mem_req, busy}, 64'b11);
      @(negedge clk);
      rst    = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_zero_outputs("midrst");
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rd    = $urandom;
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check(tg("late_ready"), {if_valid, d_valid, err, busy, mem_req}, 64'd0);
        check(tg("late_if_rdata"), if_rdata, 64'd0);
        @(negedge clk);
      end
      last_fetch = 1'b1;
      exp_if_rd  = '0;
      exp_d_rd   = '0;

      // Both requesters held continuously across four accesses.
      if_addr = $urandom & 32'hFFFF_FFFC;
      d_addr  = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      d_size  = 3'($urandom_range(0, 7));
      d_wd    = $urandom;
      if_req  = 1'b1;
      d_req   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        d_first    = PRIO || last_fetch;
        last_fetch = !d_first;
        serve(d_first, (i == 0) ? 1 : 2, $urandom_range(0, TMO - 1), $urandom, 1'b0, 1'b1);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      check(tg("final_idle"), {busy, mem_req, if_valid, d_valid, err}, 64'd0);
      env_done = 1'b1;
    end
  end

  initial begin
    wait (g_env[0].env_done && g_env[1].env_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected both environments done");
    $fatal(1, "watchdog expired");
  end

endmodule
